// File: rtl/ds_adc_pkg.sv
// Shared types and constants for the delta-sigma ADC channel sequencer.
package ds_adc_pkg;

  localparam int unsigned DW             = 20;
  localparam int unsigned OSR_BASE       = 3;
  localparam int unsigned FLUSH_CYCLES   = 4;
  localparam int unsigned SETTLE_SAMPLES = 3;
  localparam int unsigned OSR_W          = 2;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned DEC_W          = OSR_BASE + (1 << OSR_W) - 1;
  localparam int unsigned DEC_W1         = DEC_W + 1;
  localparam int unsigned FLUSH_W        = $clog2(FLUSH_CYCLES);
  localparam int unsigned SETTLE_W       = $clog2(SETTLE_SAMPLES);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;

  // Decimation factor minus one: 2^(OSR_BASE+sel) - 1
  function automatic logic [DEC_W-1:0] dec_max(input logic [OSR_W-1:0] sel);
    logic [DEC_W:0] f;
    f = DEC_W1'(1) << (OSR_BASE + 32'(sel));
    return DEC_W'(f - DEC_W1'(1));
  endfunction

endpackage

// File: rtl/ds_adc_ctrl_dec_timer.sv
// Decimation counter: wraps at max_val and emits a registered one-cycle strobe
// in the cycle the count equals max_val.
module ds_dec_timer
  import ds_adc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [DEC_W-1:0] max_val,
  output logic             dclk_en
);

  logic [DEC_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             dclk_en_q, dclk_en_d;

  // Strobe is looked ahead from the next count so it aligns with dec_cnt==max
  always_comb begin
    dec_cnt_d = dec_cnt_q;
    dclk_en_d = 1'b0;
    if (clr) begin
      dec_cnt_d = '0;
    end else if (en) begin
      dec_cnt_d = (dec_cnt_q == max_val) ? '0 : dec_cnt_q + DEC_W'(1);
      dclk_en_d = (dec_cnt_d == max_val);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
      dclk_en_q <= 1'b0;
    end else begin
      dec_cnt_q <= dec_cnt_d;
      dclk_en_q <= dclk_en_d;
    end
  end

  assign dclk_en = dclk_en_q;

endmodule

// File: rtl/ds_adc_ctrl.sv
// Delta-sigma ADC channel sequencer: flush/settle/run control, sample capture
// and valid/ready delivery with sticky overrun.
module ds_adc_ctrl
  import ds_adc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [OSR_W-1:0] osr_sel,
  output logic             dclk_en,
  output logic             ds_rst_n,
  input  logic [DW-1:0]    sample_in,
  output logic [DW-1:0]    sample_data,
  output logic             sample_valid,
  input  logic             sample_ready,
  output logic             overrun,
  output logic             busy,
  output logic [CNT_W-1:0] sample_cnt
);

  state_e                state_q, state_d;
  logic [OSR_W-1:0]      osr_q, osr_d;
  logic [FLUSH_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
  logic                  cap_stb_q, cap_stb_d;
  logic [DW-1:0]         data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ovr_q, ovr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ds_rst_n_q, ds_rst_n_d;
  logic                  busy_q, busy_d;
  logic                  strobe;
  logic                  count_cur, count_nxt, osr_chg, accept;

  assign osr_chg   = (osr_sel != osr_q);
  assign count_cur = (state_q == ST_SETTLE) || (state_q == ST_RUN);
  assign count_nxt = (state_d == ST_SETTLE) || (state_d == ST_RUN);
  assign accept    = valid_q && sample_ready;

  ds_dec_timer u_dec_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (count_cur),
    .clr     (!count_nxt),
    .max_val (dec_max(osr_q)),
    .dclk_en (strobe)
  );

  // Sequencer next state; stop overrides everything
  always_comb begin
    state_d      = state_q;
    osr_d        = osr_q;
    flush_cnt_d  = '0;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_IDLE: begin
        osr_d = osr_sel;
        if (start) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_cnt_d = flush_cnt_q + FLUSH_W'(1);
        if (flush_cnt_q == FLUSH_W'(FLUSH_CYCLES - 1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (osr_chg) begin
          osr_d   = osr_sel;
          state_d = ST_FLUSH;
        end else if (strobe) begin
          if (settle_cnt_q == SETTLE_W'(SETTLE_SAMPLES - 1)) state_d = ST_RUN;
          else settle_cnt_d = settle_cnt_q + SETTLE_W'(1);
        end
      end
      ST_RUN: begin
        if (osr_chg) begin
          osr_d   = osr_sel;
          state_d = ST_FLUSH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (stop) state_d = ST_IDLE;
    if (state_d != ST_SETTLE) settle_cnt_d = '0;
    if (state_d != ST_FLUSH) flush_cnt_d = '0;
  end

  // Capture and handshake; a capture coinciding with an accept is not an overrun
  always_comb begin
    ds_rst_n_d = count_nxt;
    busy_d     = (state_d != ST_IDLE);
    cap_stb_d  = strobe && (state_q == ST_RUN) && !stop;
    data_d     = data_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    cnt_d      = cnt_q;
    if (stop) begin
      valid_d = 1'b0;
    end else if (state_q == ST_IDLE) begin
      if (start) begin
        valid_d = 1'b0;
        ovr_d   = 1'b0;
        cnt_d   = '0;
      end
    end else if (cap_stb_q) begin
      data_d  = sample_in;
      valid_d = 1'b1;
      if (accept) cnt_d = cnt_q + CNT_W'(1);
      else if (valid_q) ovr_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      osr_q        <= '0;
      flush_cnt_q  <= '0;
      settle_cnt_q <= '0;
      cap_stb_q    <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      ovr_q        <= 1'b0;
      cnt_q        <= '0;
      ds_rst_n_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      osr_q        <= osr_d;
      flush_cnt_q  <= flush_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      cap_stb_q    <= cap_stb_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      ovr_q        <= ovr_d;
      cnt_q        <= cnt_d;
      ds_rst_n_q   <= ds_rst_n_d;
      busy_q       <= busy_d;
    end
  end

  assign dclk_en      = strobe;
  assign ds_rst_n     = ds_rst_n_q;
  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign busy         = busy_q;
  assign sample_cnt   = cnt_q;

endmodule

// File: tb/tb_ds_adc_ctrl.sv
// Directed bench for ds_adc_ctrl with a closed-form timing model and a
// scoreboard queue of captured filter outputs.
module tb_ds_adc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop;
  logic [1:0]  osr_sel;
  logic        dclk_en, ds_rst_n;
  logic [19:0] sample_in;
  logic [19:0] sample_data;
  logic        sample_valid, sample_ready;
  logic        overrun, busy;
  logic [15:0] sample_cnt;

  int n_assert;
  int n_fail;

  // expected-behaviour model
  int          cyc;
  bit          active;
  int          t0;
  int          fac;
  logic [1:0]  osr_m;
  bit          exp_valid;
  bit          exp_ovr;
  logic [15:0] exp_cnt;
  bit          cap_pend;
  logic [19:0] q[$];

  always #5 clk = ~clk;

  ds_adc_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .stop         (stop),
    .osr_sel      (osr_sel),
    .dclk_en      (dclk_en),
    .ds_rst_n     (ds_rst_n),
    .sample_in    (sample_in),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .busy         (busy),
    .sample_cnt   (sample_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit counting(input int c);
    return active && (c - t0 >= 5);
  endfunction

  function automatic bit pred_strobe(input int c);
    return counting(c) && (((c - t0 - 4) % fac) == 0);
  endfunction

  function automatic bit pred_run_strobe(input int c);
    return pred_strobe(c) && (((c - t0 - 4) / fac) >= 4);
  endfunction

  task automatic model_reset();
    active    = 1'b0;
    t0        = 0;
    fac       = 8;
    osr_m     = 2'd0;
    exp_valid = 1'b0;
    exp_ovr   = 1'b0;
    exp_cnt   = 16'd0;
    cap_pend  = 1'b0;
    q.delete();
  endtask

  task automatic check();
    chk("dclk_en", 32'(dclk_en), 32'(pred_strobe(cyc)));
    chk("ds_rst_n", 32'(ds_rst_n), 32'(counting(cyc)));
    chk("busy", 32'(busy), 32'(active));
    chk("sample_valid", 32'(sample_valid), 32'(exp_valid));
    chk("overrun", 32'(overrun), 32'(exp_ovr));
    chk("sample_cnt", 32'(sample_cnt), 32'(exp_cnt));
    if (exp_valid) begin
      if (q.size() == 0) chk("scoreboard_empty", 32'(q.size()), 32'd1);
      else chk("sample_data", 32'(sample_data), 32'(q[0]));
    end
  endtask

  // Advance one clock with the current inputs, updating the model alongside
  task automatic step();
    bit strobe_now, run_now, cap_now, acc;
    strobe_now = pred_strobe(cyc);
    run_now    = pred_run_strobe(cyc);
    cap_now    = cap_pend;
    acc        = exp_valid && sample_ready;
    cap_pend   = run_now && !stop;
    if (stop) begin
      exp_valid = 1'b0;
      active    = 1'b0;
      cap_pend  = 1'b0;
      q.delete();
    end else if (!active) begin
      if (start) begin
        active    = 1'b1;
        t0        = cyc;
        fac       = 8 << osr_sel;
        osr_m     = osr_sel;
        exp_valid = 1'b0;
        exp_ovr   = 1'b0;
        exp_cnt   = 16'd0;
        q.delete();
      end
    end else begin
      if (acc) void'(q.pop_front());
      if (cap_now) begin
        if (exp_valid && !acc) begin
          exp_ovr = 1'b1;
          if (q.size() != 0) void'(q.pop_back());
        end
        if (acc) exp_cnt++;
        q.push_back(sample_in);
        exp_valid = 1'b1;
      end else if (acc) begin
        exp_valid = 1'b0;
        exp_cnt++;
      end
      if (counting(cyc) && (osr_sel != osr_m)) begin
        t0    = cyc;
        osr_m = osr_sel;
        fac   = 8 << osr_sel;
      end
    end
    @(posedge clk);
    #1;
    if (strobe_now) sample_in = 20'($urandom);
    @(negedge clk);
    cyc++;
    check();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    osr_sel  = 2'd0;
    sample_ready = 1'b0;
    sample_in    = 20'h0;
    model_reset();

    repeat (2) @(negedge clk);
    check();
    chk("rst_data", 32'(sample_data), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Scenario 1 + overrun: factor 8, consumer stalled
    sample_in = 20'h12345;
    start = 1'b1; step(); start = 1'b0;
    repeat (45) step();
    chk("ovr_after_two_caps", 32'(overrun), 32'd1);
    sample_ready = 1'b1; step();
    chk("cnt_after_accept", 32'(sample_cnt), 32'd1);
    sample_ready = 1'b0;
    repeat (3) step();
    stop = 1'b1; step(); stop = 1'b0;
    chk("idle_after_stop", 32'(busy), 32'd0);
    chk("ovr_held_after_stop", 32'(overrun), 32'd1);
    step();

    // stop and start together in IDLE
    stop = 1'b1; start = 1'b1; step(); stop = 1'b0; start = 1'b0;
    chk("stop_beats_start", 32'(busy), 32'd0);
    step();

    // Scenario 2: factor 32, ready tied high
    osr_sel = 2'd2; sample_ready = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    chk("ovr_cleared_on_start", 32'(overrun), 32'd0);
    repeat (425) step();
    chk("cnt_ten", 32'(sample_cnt), 32'd10);
    chk("no_overrun_ready_high", 32'(overrun), 32'd0);

    // OSR change in RUN restarts flush, then stop on third settle strobe
    osr_sel = 2'd1; step();
    chk("osr_change_flush", 32'(ds_rst_n), 32'd0);
    repeat (51) step();
    chk("third_settle_strobe", 32'(dclk_en), 32'd1);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_ds_rst_n", 32'(ds_rst_n), 32'd0);
    chk("stop_no_valid", 32'(sample_valid), 32'd0);
    repeat (3) step();

    // Asynchronous reset in RUN
    osr_sel = 2'd0; sample_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    repeat (40) step();
    chk("run_valid_before_rst", 32'(sample_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_dclk_en", 32'(dclk_en), 32'd0);
    chk("arst_ds_rst_n", 32'(ds_rst_n), 32'd0);
    chk("arst_data", 32'(sample_data), 32'd0);
    chk("arst_valid", 32'(sample_valid), 32'd0);
    chk("arst_overrun", 32'(overrun), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cnt", 32'(sample_cnt), 32'd0);
    model_reset();
    @(negedge clk);
    cyc++;
    check();
    rst_n = 1'b1;
    step();

    // Scenario 1 timing again after reset
    start = 1'b1; step(); start = 1'b0;
    repeat (40) step();
    chk("rerun_valid", 32'(sample_valid), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
